ps2_transmisor: RTL and testbench



---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sincronizador.sv | 34 +++
 rtl/ps2_transmisor.sv | 174 +++++++++++++++++
 tb/tb_ps2_transmisor.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame sizes and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        REPOSO,
        INHIBIR,
        SOLICITAR,
        TRANSMITIR,
        ACK,
        FIN
    } ps2_tx_estado_t;

    localparam int unsigned PS2_N_DATOS = 8;
    localparam int unsigned PS2_N_TRAMA = 10;

    // Odd parity: data plus parity bit always carry an odd number of ones.
    function automatic logic ps2_paridad_impar(input logic [PS2_N_DATOS-1:0] i_d);
        return ~^i_d;
    endfunction

endpackage

// File: rtl/ps2_sincronizador.sv
// Two-flop synchronizer for one PS/2 pin plus a registered falling-edge pulse.
// Flops reset to 1 (idle bus level) so reset never fakes an edge from a high pin.
module ps2_sincronizador (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_nivel,
    output logic o_fe
);

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic r_fe;

    // Synchronize the pin and flag a 1->0 transition of the synchronized level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
            r_fe   <= 1'b0;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_fe   <= r_prev & ~r_s2;
        end
    end

    assign o_nivel = r_s2;
    assign o_fe    = r_fe;

endmodule

// File: rtl/ps2_transmisor.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10-bit frame on
// device clock edges, acknowledge check and timeout. The board top turns the
// oe outputs into open-drain pins (pin = oe ? 1'b0 : 1'bz).
module ps2_transmisor
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dato,
    input  logic       enviar,
    output logic       ocupado,
    output logic       listo,
    output logic       error,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned W_INH = $clog2(INHIBIT_CYC + 1);
    localparam int unsigned W_TO  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned W_BIT = $clog2(PS2_N_TRAMA + 1);

    logic w_clk_sinc;
    logic w_clk_fe;
    logic w_dat_sinc;
    logic w_dat_fe_unused;

    ps2_tx_estado_t         r_estado,  w_estado_sig;
    logic [W_INH-1:0]       r_inh,     w_inh_sig;
    logic [W_TO-1:0]        r_to,      w_to_sig;
    logic [W_BIT-1:0]       r_bit,     w_bit_sig;
    logic [PS2_N_TRAMA-1:0] r_trama,   w_trama_sig;
    logic                   r_clk_oe,  w_clk_oe_sig;
    logic                   r_dat_oe,  w_dat_oe_sig;
    logic                   r_listo,   w_listo_sig;
    logic                   r_error,   w_error_sig;

    ps2_sincronizador u_sinc_clk (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pin   (ps2_clk_i),
        .o_nivel (w_clk_sinc),
        .o_fe    (w_clk_fe)
    );

    ps2_sincronizador u_sinc_dat (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pin   (ps2_dat_i),
        .o_nivel (w_dat_sinc),
        .o_fe    (w_dat_fe_unused)
    );

    // State, counters, frame and registered line/pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= REPOSO;
            r_inh    <= '0;
            r_to     <= '0;
            r_bit    <= '0;
            r_trama  <= '0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_listo  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_inh    <= w_inh_sig;
            r_to     <= w_to_sig;
            r_bit    <= w_bit_sig;
            r_trama  <= w_trama_sig;
            r_clk_oe <= w_clk_oe_sig;
            r_dat_oe <= w_dat_oe_sig;
            r_listo  <= w_listo_sig;
            r_error  <= w_error_sig;
        end
    end

    // Next state and next registered outputs; timeout overrides the protocol.
    always_comb begin
        w_estado_sig = r_estado;
        w_inh_sig    = r_inh;
        w_to_sig     = r_to;
        w_bit_sig    = r_bit;
        w_trama_sig  = r_trama;
        w_clk_oe_sig = r_clk_oe;
        w_dat_oe_sig = r_dat_oe;
        w_listo_sig  = 1'b0;
        w_error_sig  = 1'b0;

        unique case (r_estado)
            REPOSO: begin
                w_clk_oe_sig = 1'b0;
                w_dat_oe_sig = 1'b0;
                if (enviar) begin
                    w_trama_sig  = {1'b1, ps2_paridad_impar(dato), dato};
                    w_inh_sig    = '0;
                    w_bit_sig    = '0;
                    w_clk_oe_sig = 1'b1;
                    w_estado_sig = INHIBIR;
                end
            end
            INHIBIR: begin
                if (r_inh == W_INH'(INHIBIT_CYC - 1)) begin
                    w_dat_oe_sig = 1'b1;
                    w_estado_sig = SOLICITAR;
                end else begin
                    w_inh_sig = r_inh + 1'b1;
                end
            end
            SOLICITAR: begin
                w_to_sig     = '0;
                w_clk_oe_sig = 1'b0;
                w_estado_sig = TRANSMITIR;
            end
            TRANSMITIR: begin
                w_to_sig = r_to + 1'b1;
                if (w_clk_fe) begin
                    w_dat_oe_sig = ~r_trama[0];
                    w_trama_sig  = {1'b0, r_trama[PS2_N_TRAMA-1:1]};
                    w_bit_sig    = r_bit + 1'b1;
                    if (r_bit == W_BIT'(PS2_N_TRAMA - 1)) begin
                        w_estado_sig = ACK;
                    end
                end
            end
            ACK: begin
                w_to_sig = r_to + 1'b1;
                if (w_clk_fe) begin
                    if (!w_dat_sinc) begin
                        w_estado_sig = FIN;
                    end else begin
                        w_error_sig  = 1'b1;
                        w_dat_oe_sig = 1'b0;
                        w_estado_sig = REPOSO;
                    end
                end
            end
            FIN: begin
                w_to_sig = r_to + 1'b1;
                if (w_clk_sinc && w_dat_sinc) begin
                    w_listo_sig  = 1'b1;
                    w_dat_oe_sig = 1'b0;
                    w_estado_sig = REPOSO;
                end
            end
            default: begin
                w_clk_oe_sig = 1'b0;
                w_dat_oe_sig = 1'b0;
                w_estado_sig = REPOSO;
            end
        endcase

        if ((r_estado == TRANSMITIR || r_estado == ACK || r_estado == FIN) &&
            r_to == W_TO'(TIMEOUT_CYC - 1)) begin
            w_clk_oe_sig = 1'b0;
            w_dat_oe_sig = 1'b0;
            w_listo_sig  = 1'b0;
            w_error_sig  = 1'b1;
            w_estado_sig = REPOSO;
        end
    end

    assign ocupado    = (r_estado != REPOSO);
    assign listo      = r_listo;
    assign error      = r_error;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_transmisor.sv
// Bench for ps2_transmisor: a PS/2 device model on the open-drain pair, a
// cycle-level expectation model for the handshake outputs, directed transfers.
module tb_ps2_transmisor;

    localparam int INH = 50;
    localparam int TO  = 2000;
    localparam int H   = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dato = '0;
    logic       enviar = 1'b0;
    logic       ocupado, listo, error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_i, ps2_dat_i;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [10:0] dev_bits = '0;
    int          dev_nbits = 0;
    bit          dev_abort = 1'b0;
    bit          exp_ack   = 1'b1;

    int n_listo = 0, n_error = 0;
    int clk_run = 0, last_run = 0;
    int t_rel = 0, t_err = 0;
    bit prev_clk_oe = 1'b0;

    bit m_busy = 1'b0, m_acc = 1'b0;
    int m_clk_left = 0, m_to = 0;

    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    ps2_transmisor #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dato       (dato),
        .enviar     (enviar),
        .ocupado    (ocupado),
        .listo      (listo),
        .error      (error),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame as the device sees it on its rising edges, index 0 first.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic p;
        p = (($countones(d) % 2) == 0);
        return {1'b1, p, d, 1'b0};
    endfunction

    // Pulse counters, inhibit length and release/error timestamps.
    always @(negedge clk) begin
        if (listo) n_listo++;
        if (error) begin
            n_error++;
            t_err = cyc;
        end
        if (ps2_clk_oe) clk_run++;
        else if (prev_clk_oe) begin
            last_run = clk_run;
            clk_run  = 0;
            if (ocupado) t_rel = cyc;
        end
        prev_clk_oe = ps2_clk_oe;
    end

    // Per-cycle expectation: busy window, inhibit span, timeout, end pulses.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outputs", {ocupado, listo, error, ps2_clk_oe, ps2_dat_oe}, 5'b0);
            m_busy = 1'b0; m_acc = 1'b0; m_clk_left = 0; m_to = 0;
        end else begin
            if (m_acc) begin
                m_busy = 1'b1; m_clk_left = INH + 1; m_to = 0; m_acc = 1'b0;
            end
            if (m_busy && m_clk_left == 0 && m_to == TO) begin
                chk("timeout_end", {ocupado, listo, error, ps2_clk_oe, ps2_dat_oe}, 5'b00100);
                m_busy = 1'b0;
            end else if (m_busy && m_clk_left == 0 && (listo || error)) begin
                chk("end_pulse", {ocupado, listo, error, ps2_clk_oe, ps2_dat_oe},
                    {1'b0, exp_ack, !exp_ack, 2'b00});
                m_busy = 1'b0;
            end else begin
                chk("cyc_pulses", {listo, error}, 2'b00);
                chk("cyc_ocupado", ocupado, m_busy);
                chk("cyc_clk_oe", ps2_clk_oe, m_busy && m_clk_left > 0);
                if (!m_busy || m_clk_left > 0)
                    chk("cyc_dat_oe", ps2_dat_oe, m_busy && m_clk_left == 1);
            end
            if (m_busy) begin
                if (m_clk_left > 0) m_clk_left--;
                else m_to++;
            end
            m_acc = enviar && !m_busy;
        end
    end

    task automatic send(input logic [7:0] d);
        @(posedge clk); #1;
        dato   = d;
        enviar = 1'b1;
        @(posedge clk); #1;
        enviar = 1'b0;
    endtask

    // Device side: detect request-to-send, clock 10 bits, then ack (or not).
    task automatic dev_xfer(input bit do_ack);
        int k;
        dev_nbits = 0;
        dev_bits  = '0;
        k = 0;
        while (!(ps2_clk_i && !ps2_dat_i) && k < INH + 200) begin
            @(negedge clk);
            k++;
        end
        if (!(ps2_clk_i && !ps2_dat_i)) begin
            chk("dev_rts_seen", 0, 1);
            return;
        end
        dev_bits[0] = ps2_dat_i;
        dev_nbits   = 1;
        for (int i = 1; i < 11; i++) begin
            if (dev_abort) break;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            #1;
            dev_bits[i] = ps2_dat_i;
            dev_nbits++;
        end
        if (dev_abort) begin
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            return;
        end
        repeat (H / 2) @(negedge clk);
        if (do_ack) dev_dat_low = 1'b1;
        repeat (H / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (H / 2) @(negedge clk);
        dev_dat_low = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        @(negedge clk);
        while (ocupado && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("idle_within_bound", ocupado, 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_bits(input int n);
        int k;
        k = 0;
        while (dev_nbits < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("dev_bits_reached", dev_nbits >= n, 1);
    endtask

    task automatic run_xfer(input logic [7:0] d, input bit ack);
        exp_ack = ack;
        n_listo = 0;
        n_error = 0;
        fork
            dev_xfer(ack);
            send(d);
        join
        wait_idle(3000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_state", {ocupado, listo, error, ps2_clk_oe, ps2_dat_oe}, 5'b0);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED acknowledged
        run_xfer(8'hED, 1'b1);
        chk("ed_bits", dev_bits, 11'b11111011010);
        chk("ed_nbits", dev_nbits, 11);
        chk("ed_listo", n_listo, 1);
        chk("ed_error", n_error, 0);

        // 0xF4 acknowledged, inhibit length
        run_xfer(8'hF4, 1'b1);
        chk("f4_bits", dev_bits, 11'b10111101000);
        chk("f4_bits_model", dev_bits, exp_frame(8'hF4));
        chk("f4_listo", n_listo, 1);
        chk("f4_clk_low_len", last_run, INH + 1);

        // No acknowledge
        run_xfer(8'h55, 1'b0);
        chk("nack_bits", dev_bits, exp_frame(8'h55));
        chk("nack_error", n_error, 1);
        chk("nack_listo", n_listo, 0);
        chk("nack_released", {ocupado, ps2_clk_oe, ps2_dat_oe}, 3'b0);

        // Silent device: timeout
        n_listo = 0; n_error = 0;
        send(8'hA3);
        wait_idle(3000);
        chk("to_error", n_error, 1);
        chk("to_listo", n_listo, 0);
        chk("to_delay", t_err - t_rel, TO);
        chk("to_clk_low_len", last_run, INH + 1);
        chk("to_released", {ps2_clk_oe, ps2_dat_oe}, 2'b0);

        // Second request mid-frame is ignored
        exp_ack = 1'b1; n_listo = 0; n_error = 0;
        fork
            dev_xfer(1'b1);
            begin
                send(8'h3C);
                wait_bits(5);
                send(8'h81);
            end
        join
        wait_idle(3000);
        chk("mid_bits", dev_bits, exp_frame(8'h3C));
        chk("mid_listo", n_listo, 1);
        chk("mid_error", n_error, 0);

        // Reset after the 4th data bit
        exp_ack = 1'b1; n_listo = 0; n_error = 0; dev_abort = 1'b0;
        fork
            dev_xfer(1'b1);
            begin
                send(8'hED);
                wait_bits(5);
                repeat (H + 10) @(negedge clk);
                chk("pre_rst_dat_oe", ps2_dat_oe, 1);
                #2 rst = 1'b1;
                #1;
                chk("rst_async_release", {ocupado, ps2_clk_oe, ps2_dat_oe}, 3'b0);
                dev_abort = 1'b1;
                repeat (3) @(negedge clk);
                #2 rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        chk("rst_no_listo", n_listo, 0);
        chk("rst_no_error", n_error, 0);
        dev_abort = 1'b0;

        run_xfer(8'hED, 1'b1);
        chk("post_rst_bits", dev_bits, 11'b11111011010);
        chk("post_rst_listo", n_listo, 1);
        chk("post_rst_error", n_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
